// File: rtl/reg_file_ctrl.sv
// Sequencing master for the 8x8 register file: decodes one instruction per
// handshake, reads operands, runs a small ALU and issues a one-cycle write-back.
module reg_file_ctrl #(
  parameter int READ_WAIT = 1
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic [31:0] INSTR,
  input  logic        INSTR_VALID,
  output logic        INSTR_READY,
  output logic [2:0]  OUT1ADDRESS,
  output logic [2:0]  OUT2ADDRESS,
  input  logic [7:0]  REGOUT1,
  input  logic [7:0]  REGOUT2,
  output logic [2:0]  INADDRESS,
  output logic [7:0]  IN,
  output logic        WRITE,
  output logic        DONE,
  output logic        ERROR
);

  typedef enum logic [2:0] {IDLE, READ, EXEC, WB, ERR} state_t;

  localparam logic [7:0] OP_LOADI = 8'h00;
  localparam logic [7:0] OP_MOV   = 8'h01;
  localparam logic [7:0] OP_ADD   = 8'h02;
  localparam logic [7:0] OP_SUB   = 8'h03;
  localparam logic [7:0] OP_AND   = 8'h04;
  localparam logic [7:0] OP_OR    = 8'h05;
  localparam logic [7:0] WAIT_LAST = 8'(READ_WAIT - 1);

  state_t     state_q, state_d;
  logic [7:0] wait_q, wait_d;
  logic [7:0] opcode_q, imm_q;
  logic [2:0] dest_q;
  logic [7:0] op1_q, op2_q;
  logic       ready_q, write_q, done_q, error_q;
  logic [2:0] out1_q, out2_q, inAddr_q;
  logic [7:0] in_q;
  logic [7:0] aluResult;
  logic       accept;
  logic       unusedInstrBits;

  assign unusedInstrBits = ^{INSTR[23:19], INSTR[15:11]};

  // ready_q is only ever high in IDLE, so it doubles as the accept gate
  assign accept = ready_q & INSTR_VALID;

  always_comb begin
    state_d = state_q;
    wait_d  = wait_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          if (INSTR[31:24] == OP_LOADI) begin
            state_d = EXEC;
          end else if (INSTR[31:24] <= OP_OR) begin
            state_d = READ;
            wait_d  = 8'd0;
          end else begin
            state_d = ERR;
          end
        end
      end
      READ: begin
        if (wait_q == WAIT_LAST) state_d = EXEC;
        else                     wait_d  = wait_q + 8'd1;
      end
      EXEC:    state_d = WB;
      WB:      state_d = IDLE;
      ERR:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    aluResult = 8'h00;
    case (opcode_q)
      OP_LOADI: aluResult = imm_q;
      OP_MOV:   aluResult = op2_q;
      OP_ADD:   aluResult = op1_q + op2_q;
      OP_SUB:   aluResult = op1_q + (~op2_q + 8'd1);
      OP_AND:   aluResult = op1_q & op2_q;
      OP_OR:    aluResult = op1_q | op2_q;
      default:  aluResult = 8'h00;
    endcase
  end

  // Outputs are registered from the next state so each is valid for the whole cycle
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q  <= IDLE;
      wait_q   <= 8'd0;
      opcode_q <= 8'h00;
      imm_q    <= 8'h00;
      dest_q   <= 3'd0;
      op1_q    <= 8'h00;
      op2_q    <= 8'h00;
      ready_q  <= 1'b0;
      write_q  <= 1'b0;
      done_q   <= 1'b0;
      error_q  <= 1'b0;
      out1_q   <= 3'd0;
      out2_q   <= 3'd0;
      inAddr_q <= 3'd0;
      in_q     <= 8'h00;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      ready_q <= (state_d == IDLE);
      write_q <= (state_d == WB);
      done_q  <= (state_d == WB);
      error_q <= (state_d == ERR);
      if (accept) begin
        opcode_q <= INSTR[31:24];
        dest_q   <= INSTR[18:16];
        imm_q    <= INSTR[7:0];
        if (state_d == READ) begin
          out1_q <= INSTR[10:8];
          out2_q <= INSTR[2:0];
        end
      end
      if (state_q == READ && state_d == EXEC) begin
        op1_q <= REGOUT1;
        op2_q <= REGOUT2;
      end
      if (state_q == EXEC) begin
        inAddr_q <= dest_q;
        in_q     <= aluResult;
      end
    end
  end

  assign INSTR_READY = ready_q;
  assign OUT1ADDRESS = out1_q;
  assign OUT2ADDRESS = out2_q;
  assign INADDRESS   = inAddr_q;
  assign IN          = in_q;
  assign WRITE       = write_q;
  assign DONE        = done_q;
  assign ERROR       = error_q;

endmodule

// File: tb/tb_reg_file_ctrl.sv
// Directed bench for reg_file_ctrl: two instances (READ_WAIT=1 and 3), each
// attached to a simple register file model; one is observed at a time.
module tb_reg_file_ctrl;

  logic        CLK = 1'b0;
  logic        RESET;
  logic [31:0] INSTR;
  logic        instrValid;
  logic        useB;
  int          checks = 0;
  int          errors = 0;

  logic       readyA, writeA, doneA, errorA;
  logic [2:0] out1A, out2A, inAddrA;
  logic [7:0] regOut1A, regOut2A, inA;
  logic       readyB, writeB, doneB, errorB;
  logic [2:0] out1B, out2B, inAddrB;
  logic [7:0] regOut1B, regOut2B, inB;
  logic       validA, validB;

  logic [7:0] rfA [8] = '{default: 8'h00};
  logic [7:0] rfB [8] = '{default: 8'h00};

  logic       obsReady, obsWrite, obsDone, obsError;
  logic [2:0] obsOut1, obsOut2, obsInAddr;
  logic [7:0] obsIn;

  always #5 CLK = ~CLK;

  assign validA = instrValid & ~useB;
  assign validB = instrValid & useB;

  reg_file_ctrl #(.READ_WAIT(1)) dutA (
    .CLK(CLK), .RESET(RESET), .INSTR(INSTR), .INSTR_VALID(validA),
    .INSTR_READY(readyA), .OUT1ADDRESS(out1A), .OUT2ADDRESS(out2A),
    .REGOUT1(regOut1A), .REGOUT2(regOut2A), .INADDRESS(inAddrA), .IN(inA),
    .WRITE(writeA), .DONE(doneA), .ERROR(errorA)
  );

  reg_file_ctrl #(.READ_WAIT(3)) dutB (
    .CLK(CLK), .RESET(RESET), .INSTR(INSTR), .INSTR_VALID(validB),
    .INSTR_READY(readyB), .OUT1ADDRESS(out1B), .OUT2ADDRESS(out2B),
    .REGOUT1(regOut1B), .REGOUT2(regOut2B), .INADDRESS(inAddrB), .IN(inB),
    .WRITE(writeB), .DONE(doneB), .ERROR(errorB)
  );

  // Register file models: commit on the edge ending the write cycle
  always @(posedge CLK) begin
    if (writeA) rfA[inAddrA] <= inA;
    if (writeB) rfB[inAddrB] <= inB;
  end

  assign regOut1A = rfA[out1A];
  assign regOut2A = rfA[out2A];
  assign regOut1B = rfB[out1B];
  assign regOut2B = rfB[out2B];

  assign obsReady  = useB ? readyB  : readyA;
  assign obsWrite  = useB ? writeB  : writeA;
  assign obsDone   = useB ? doneB   : doneA;
  assign obsError  = useB ? errorB  : errorA;
  assign obsOut1   = useB ? out1B   : out1A;
  assign obsOut2   = useB ? out2B   : out2A;
  assign obsInAddr = useB ? inAddrB : inAddrA;
  assign obsIn     = useB ? inB     : inA;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, actual, expected);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Waits (bounded) for ready, then presents the instruction for the accept edge
  task automatic applyStimulus(input logic [31:0] ins);
    int n;
    n = 0;
    while (!obsReady && n < 10) begin
      tick();
      n++;
    end
    if (!obsReady) checkOutput("ready_timeout", 32'd0, 32'd1);
    INSTR = ins;
    instrValid = 1'b1;
    tick();
    instrValid = 1'b0;
  endtask

  task automatic runInstr(input string tag, input logic [31:0] ins, input logic [2:0] expDest,
                          input logic [7:0] expVal, input int expLat);
    int lat;
    lat = 0;
    applyStimulus(ins);
    for (int c = 1; c <= 20; c++) begin
      if (obsWrite) begin
        lat = c;
        break;
      end
      if (ins[31:24] != 8'h00) begin
        checkOutput({tag, "_rdaddr1"}, obsOut1, ins[10:8]);
        checkOutput({tag, "_rdaddr2"}, obsOut2, ins[2:0]);
      end
      checkOutput({tag, "_busy"}, obsReady, 1'b0);
      tick();
    end
    checkOutput({tag, "_latency"}, lat, expLat);
    checkOutput({tag, "_waddr"}, obsInAddr, expDest);
    checkOutput({tag, "_wdata"}, obsIn, expVal);
    checkOutput({tag, "_done"}, obsDone, 1'b1);
    checkOutput({tag, "_noerr"}, obsError, 1'b0);
    tick();
    checkOutput({tag, "_write_once"}, obsWrite, 1'b0);
    checkOutput({tag, "_done_once"}, obsDone, 1'b0);
    checkOutput({tag, "_ready_back"}, obsReady, 1'b1);
  endtask

  task automatic resetAndCheck(input string tag);
    RESET = 1'b1;
    instrValid = 1'b0;
    tick();
    tick();
    checkOutput({tag, "_ready"}, obsReady, 1'b0);
    checkOutput({tag, "_write"}, obsWrite, 1'b0);
    checkOutput({tag, "_done"}, obsDone, 1'b0);
    checkOutput({tag, "_error"}, obsError, 1'b0);
    checkOutput({tag, "_outs"}, {obsOut1, obsOut2, obsInAddr, obsIn}, 32'd0);
    RESET = 1'b0;
  endtask

  initial begin
    logic [31:0] seq [3];
    logic [2:0]  wrAddr [3];
    logic [7:0]  wrVal [3];
    int          idx, nWr, extra;
    logic        acc;

    RESET = 1'b1;
    INSTR = 32'h0;
    instrValid = 1'b0;
    useB = 1'b0;

    resetAndCheck("rstA");
    runInstr("loadi_2A", 32'h0001_002A, 3'd1, 8'h2A, 2);
    runInstr("loadi_F0", 32'h0001_00F0, 3'd1, 8'hF0, 2);
    runInstr("loadi_20", 32'h0002_0020, 3'd2, 8'h20, 2);
    runInstr("add", 32'h0203_0102, 3'd3, 8'h10, 3);
    runInstr("sub", 32'h0304_0201, 3'd4, 8'h30, 3);
    runInstr("and", 32'h0406_0201, 3'd6, 8'h20, 3);
    runInstr("or", 32'h0507_0201, 3'd7, 8'hF0, 3);
    runInstr("mov", 32'h0105_0001, 3'd5, 8'hF0, 3);
    runInstr("raw_add", 32'h0206_0505, 3'd6, 8'hE0, 3);
    checkOutput("rf_r3", rfA[3], 8'h10);
    checkOutput("rf_r6", rfA[6], 8'hE0);

    // Illegal opcode
    applyStimulus(32'h0700_0000);
    checkOutput("illegal_error", obsError, 1'b1);
    checkOutput("illegal_write", obsWrite, 1'b0);
    checkOutput("illegal_done", obsDone, 1'b0);
    checkOutput("illegal_busy", obsReady, 1'b0);
    tick();
    checkOutput("illegal_error_once", obsError, 1'b0);
    checkOutput("illegal_ready", obsReady, 1'b1);
    checkOutput("illegal_write2", obsWrite, 1'b0);

    // Reset during READ of an add into R0
    applyStimulus(32'h0200_0102);
    RESET = 1'b1;
    tick();
    checkOutput("abort_write", obsWrite, 1'b0);
    checkOutput("abort_ready", obsReady, 1'b0);
    RESET = 1'b0;
    extra = 0;
    for (int c = 0; c < 6; c++) begin
      if (obsWrite) extra++;
      tick();
    end
    checkOutput("abort_no_wb", extra, 0);
    checkOutput("abort_rf_r0", rfA[0], 8'h00);
    runInstr("post_reset_loadi", 32'h0000_0055, 3'd0, 8'h55, 2);
    checkOutput("rf_r0", rfA[0], 8'h55);

    // Back-to-back with INSTR_VALID held high
    seq[0] = 32'h0001_0011;
    seq[1] = 32'h0002_0022;
    seq[2] = 32'h0203_0102;
    idx = 0;
    nWr = 0;
    INSTR = seq[0];
    instrValid = 1'b1;
    for (int c = 0; c < 40 && nWr < 3; c++) begin
      if (obsWrite) begin
        if (nWr < 3) begin
          wrAddr[nWr] = obsInAddr;
          wrVal[nWr] = obsIn;
        end
        nWr++;
      end
      acc = obsReady && instrValid;
      tick();
      if (acc) begin
        idx++;
        if (idx < 3) INSTR = seq[idx];
        else instrValid = 1'b0;
      end
    end
    instrValid = 1'b0;
    checkOutput("b2b_accepts", idx, 3);
    checkOutput("b2b_writes", nWr, 3);
    checkOutput("b2b_w0", {wrAddr[0], wrVal[0]}, {3'd1, 8'h11});
    checkOutput("b2b_w1", {wrAddr[1], wrVal[1]}, {3'd2, 8'h22});
    checkOutput("b2b_w2", {wrAddr[2], wrVal[2]}, {3'd3, 8'h33});
    extra = 0;
    for (int c = 0; c < 5; c++) begin
      if (obsWrite) extra++;
      tick();
    end
    checkOutput("b2b_no_dup", extra, 0);

    // READ_WAIT=3 instance
    useB = 1'b1;
    resetAndCheck("rstB");
    runInstr("B_loadi_05", 32'h0001_0005, 3'd1, 8'h05, 2);
    runInstr("B_loadi_03", 32'h0002_0003, 3'd2, 8'h03, 2);
    runInstr("B_sub", 32'h0303_0102, 3'd3, 8'h02, 5);
    runInstr("B_add", 32'h0204_0301, 3'd4, 8'h07, 5);
    checkOutput("B_rf_r4", rfB[4], 8'h07);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
